lif_run_sequencer: RTL

LIF_RUN_SEQUENCER -- requirements
Module: lif_run_sequencer

---
 rtl/lif_ctrl_pkg.sv | 26 ++
 rtl/lif_spike_counter.sv | 23 ++
 rtl/lif_run_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lif_ctrl_pkg.sv
// Shared encodings and reset constants for the LIF run sequencer.
package lif_ctrl_pkg;

  // Command opcode carried in bits [7:6] of a byte accepted in IDLE
  typedef enum logic [1:0] {
    OP_LOAD_W = 2'b00,
    OP_LOAD_I = 2'b01,
    OP_CONFIG = 2'b10,
    OP_RUN    = 2'b11
  } opcode_e;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CFG     = 3'd2,
    ST_RUN_LEN = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Reset values for the neuron configuration registers
  localparam int unsigned THRESHOLD_INIT  = 5;
  localparam logic        WEIGHT_INIT_BIT = 1'b1;  // weights reset to all ones

endpackage

// File: rtl/lif_spike_counter.sv
// Saturating spike counter: synchronous clear, increment, hold at all-ones.
module lif_spike_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  // Clear has priority; increments stop once the counter is saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lif_run_sequencer.sv
// Byte-command sequencer that loads synapse weights/inputs, configures the
// leak shift and threshold, and runs the neuron for a programmed cycle count.
module lif_run_sequencer
  import lif_ctrl_pkg::*;
#(
  parameter int N_STAGES = 5,
  parameter int CNT_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2**N_STAGES-1:0] weights,
  output logic [2**N_STAGES-1:0] inputs,
  output logic [2:0]             shift,
  output logic [N_STAGES:0]      threshold,
  output logic                   neuron_enable,
  input  logic                   is_spike,
  output logic                   busy,
  output logic [CNT_BITS-1:0]    spike_count,
  output logic                   done
);

  localparam int SYNAPSES   = 2**N_STAGES;
  localparam int LOAD_BYTES = (SYNAPSES / 8 > 1) ? SYNAPSES / 8 : 1;
  localparam int LB_W       = (LOAD_BYTES > 1) ? $clog2(LOAD_BYTES) : 1;
  localparam logic [LB_W-1:0] LOAD_LAST = LB_W'(LOAD_BYTES - 1);

  state_e              state;
  logic                load_to_inputs;
  logic [LB_W-1:0]     load_idx;
  logic                cfg_second;
  logic [8:0]          run_left;
  logic                accept;
  logic                cnt_clear;
  logic                cnt_inc;
  logic [SYNAPSES-1:0] weights_shifted;
  logic [SYNAPSES-1:0] inputs_shifted;

  assign accept    = in_valid && in_ready;
  assign cnt_clear = accept && (state == ST_RUN_LEN);
  assign cnt_inc   = neuron_enable && is_spike;

  // Payload bytes shift in from the bottom; narrow arrays take the low bits directly
  generate
    if (SYNAPSES > 8) begin : g_wide
      assign weights_shifted = {weights[SYNAPSES-9:0], in_data};
      assign inputs_shifted  = {inputs[SYNAPSES-9:0], in_data};
    end else begin : g_narrow
      assign weights_shifted = in_data[SYNAPSES-1:0];
      assign inputs_shifted  = in_data[SYNAPSES-1:0];
    end
  endgenerate

  // Command FSM; status outputs are registered alongside each state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      weights        <= {SYNAPSES{WEIGHT_INIT_BIT}};
      inputs         <= '0;
      shift          <= '0;
      threshold      <= (N_STAGES + 1)'(THRESHOLD_INIT);
      neuron_enable  <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      in_ready       <= 1'b1;
      load_to_inputs <= 1'b0;
      load_idx       <= '0;
      cfg_second     <= 1'b0;
      run_left       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            case (opcode_e'(in_data[7:6]))
              OP_LOAD_W: begin
                state          <= ST_LOAD;
                load_to_inputs <= 1'b0;
                load_idx       <= '0;
              end
              OP_LOAD_I: begin
                state          <= ST_LOAD;
                load_to_inputs <= 1'b1;
                load_idx       <= '0;
              end
              OP_CONFIG: begin
                state      <= ST_CFG;
                cfg_second <= 1'b0;
              end
              OP_RUN: begin
                state <= ST_RUN_LEN;
              end
            endcase
          end
        end

        ST_LOAD: begin
          if (accept) begin
            if (load_to_inputs) begin
              inputs <= inputs_shifted;
            end else begin
              weights <= weights_shifted;
            end
            if (load_idx == LOAD_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              load_idx <= load_idx + 1'b1;
            end
          end
        end

        ST_CFG: begin
          if (accept) begin
            if (!cfg_second) begin
              shift      <= in_data[2:0];
              cfg_second <= 1'b1;
            end else begin
              threshold <= in_data[N_STAGES:0];
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end

        ST_RUN_LEN: begin
          if (accept) begin
            // a zero length byte encodes 256 cycles via the ninth bit
            run_left      <= {~|in_data, in_data};
            state         <= ST_RUN;
            neuron_enable <= 1'b1;
            in_ready      <= 1'b0;
          end
        end

        ST_RUN: begin
          if (run_left == 9'd1) begin
            state         <= ST_DONE;
            neuron_enable <= 1'b0;
            done          <= 1'b1;
          end else begin
            run_left <= run_left - 1'b1;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end

        default: begin
          state         <= ST_IDLE;
          neuron_enable <= 1'b0;
          done          <= 1'b0;
          busy          <= 1'b0;
          in_ready      <= 1'b1;
        end
      endcase
    end
  end

  lif_spike_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_spike_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (spike_count)
  );

endmodule
